bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_pkg.sv | 24 ++
 rtl/bin2bcd_seq_if.sv | 32 +++
 rtl/bin2bcd_seq_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 tb/tb_bin2bcd_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared constants and types for the display-path BCD converter
package bin2bcd_seq_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ_ADD       = 4'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done handshake and result bus of the BCD converter
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) ();

    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     nz_mask;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  nz_mask
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output nz_mask
    );

endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// rtl/bin2bcd_seq_digit_adj.sv - double-dabble digit correction: add 3 when digit >= 5
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Inputs are 0..9, so the 4-bit sum never carries out.
    assign adjusted = (digit >= ADJ_THRESHOLD) ? (digit + ADJ_ADD) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD, one bit per clock
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic          clock,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]     nz_q, nz_d;
    logic                  done_q, done_d;

    logic [4*DIGITS-1:0]   adj_scratch;
    logic [4*DIGITS-1:0]   shift_scratch;
    logic [DIGITS-1:0]     nz_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch_q[4*g +: 4]),
            .adjusted (adj_scratch[4*g +: 4])
        );
    end

    assign shift_scratch = {adj_scratch[4*DIGITS-2:0], shift_q[WIDTH-1]};

    // Running OR from the top digit down; digit 0 always shows.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        nz_shift = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc         = acc | (|shift_scratch[4*i +: 4]);
            nz_shift[i] = acc;
        end
        nz_shift[0] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        nz_d      = nz_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shift_scratch;
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shift_scratch;
                    nz_d    = nz_shift;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            nz_q      <= DIGITS'(1);
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            nz_q      <= nz_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.bcd     = bcd_q;
    assign bus.nz_mask = nz_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus ();

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic start_conv(input logic [15:0] v);
        bus.bin   = v;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) bcnt++;
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        tests++;
        if (bus.bcd !== 20'h00000 || bus.nz_mask !== 5'b00001) begin
            fails++;
            $display("FAIL reset_out bcd=%h nz=%b expected 00000 00001", bus.bcd, bus.nz_mask);
        end
    endtask

    task automatic test_zero();
        int cyc, bcnt;
        start_conv(16'd0);
        wait_done(cyc, bcnt);
        tests++;
        if (cyc !== 16 || bcnt !== 16) begin
            fails++;
            $display("FAIL zero_latency cycles=%0d busy_cycles=%0d expected 16 16", cyc, bcnt);
        end
        tests++;
        if (bus.bcd !== 20'h00000 || bus.nz_mask !== 5'b00001 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_result bcd=%h nz=%b busy=%b expected 00000 00001 0",
                     bus.bcd, bus.nz_mask, bus.busy);
        end
        @(negedge clock);
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse_width done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        start_conv(16'd50);
        wait_done(cyc, bcnt);
        tests++;
        if (cyc !== 16 || bus.bcd !== 20'h00050 || bus.nz_mask !== 5'b00011) begin
            fails++;
            $display("FAIL b2b_first cycles=%0d bcd=%h nz=%b expected 16 00050 00011",
                     cyc, bus.bcd, bus.nz_mask);
        end
        start_conv(16'd40);
        wait_done(cyc, bcnt);
        tests++;
        if (cyc + 1 !== 17 || bus.bcd !== 20'h00040 || bus.nz_mask !== 5'b00011) begin
            fails++;
            $display("FAIL b2b_second period=%0d bcd=%h nz=%b expected 17 00040 00011",
                     cyc + 1, bus.bcd, bus.nz_mask);
        end
    endtask

    task automatic test_values();
        logic [15:0] vin  [4] = '{16'd65535, 16'd1234, 16'd9, 16'd10000};
        logic [19:0] vbcd [4] = '{20'h65535, 20'h01234, 20'h00009, 20'h10000};
        logic [4:0]  vnz  [4] = '{5'b11111, 5'b01111, 5'b00001, 5'b11111};
        int cyc, bcnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            start_conv(vin[i]);
            wait_done(cyc, bcnt);
            tests++;
            if (cyc !== 16 || bus.bcd !== vbcd[i] || bus.nz_mask !== vnz[i]) begin
                fails++;
                $display("FAIL value_%0d cycles=%0d bcd=%h nz=%b expected 16 %h %b",
                         vin[i], cyc, bus.bcd, bus.nz_mask, vbcd[i], vnz[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int dn;
        logic [19:0] got;
        @(negedge clock);
        start_conv(16'd10);
        repeat (4) @(negedge clock);
        start_conv(16'd20);
        dn  = 0;
        got = '1;
        for (int i = 0; i < 30; i++) begin
            if (bus.done) begin
                dn++;
                got = bus.bcd;
            end
            @(negedge clock);
        end
        tests++;
        if (dn !== 1 || got !== 20'h00010) begin
            fails++;
            $display("FAIL busy_ignore done_count=%0d bcd=%h expected 1 00010", dn, got);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bcnt, dn;
        @(negedge clock);
        start_conv(16'd50);
        wait_done(cyc, bcnt);
        tests++;
        if (bus.bcd !== 20'h00050) begin
            fails++;
            $display("FAIL reset_mid_prior bcd=%h expected 00050", bus.bcd);
        end
        @(negedge clock);
        start_conv(16'd40);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 20'h00000 || bus.nz_mask !== 5'b00001) begin
            fails++;
            $display("FAIL reset_mid_state busy=%b done=%b bcd=%h nz=%b expected 0 0 00000 00001",
                     bus.busy, bus.done, bus.bcd, bus.nz_mask);
        end
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.done) dn++;
        end
        tests++;
        if (dn !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done done_count=%0d expected 0", dn);
        end
        start_conv(16'd20);
        wait_done(cyc, bcnt);
        tests++;
        if (cyc !== 16 || bus.bcd !== 20'h00020) begin
            fails++;
            $display("FAIL reset_mid_restart cycles=%0d bcd=%h expected 16 00020", cyc, bus.bcd);
        end
    endtask

    task automatic test_hold_start();
        int idx [$];
        int bad;
        int cyc, bcnt;
        @(negedge clock);
        bus.bin   = 16'd3;
        bus.start = 1'b1;
        bad       = 0;
        for (int i = 1; i <= 52; i++) begin
            @(negedge clock);
            if (bus.done) idx.push_back(i);
            if (idx.size() > 0 && bus.bcd !== 20'h00003) bad++;
        end
        bus.start = 1'b0;
        tests++;
        if (idx.size() !== 3) begin
            fails++;
            $display("FAIL hold_count pulses=%0d expected 3", idx.size());
        end else begin
            tests++;
            if (idx[0] !== 17 || idx[1] !== 34 || idx[2] !== 51) begin
                fails++;
                $display("FAIL hold_period at=%0d,%0d,%0d expected 17,34,51", idx[0], idx[1], idx[2]);
            end
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL hold_bcd_steady bad_cycles=%0d expected 0", bad);
        end
        wait_done(cyc, bcnt);
        tests++;
        if (cyc >= 40 || bus.bcd !== 20'h00003) begin
            fails++;
            $display("FAIL hold_drain cycles=%0d bcd=%h expected <40 00003", cyc, bus.bcd);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        test_reset();
        test_zero();
        test_back_to_back();
        test_values();
        test_busy_ignore();
        test_reset_mid();
        test_hold_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
